// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
//   Host-side request controller in front of a single-port memory
//   (EN=1 write, EN=0 read). One request is in flight at a time:
//   accept -> drive memory -> return a single response beat that the
//   host may stall. Reads that never see Valid_out within TIMEOUT
//   cycles of waiting return an error. Completed writes, good reads
//   and timed-out reads are tallied in saturating counters.
//
// Ports
//   CLK, RST          rising-edge clock, asynchronous active-low reset
//   req_*             host request channel (valid/ready handshake)
//   rsp_*             host response channel (valid/ready handshake)
//   mem_data_in       memory Data_in   (registered)
//   mem_address       memory Address   (registered)
//   mem_en            memory EN        (1 = write)
//   mem_data_out      memory Data_out
//   mem_valid_out     memory Valid_out (read data valid)
//   wr_count, rd_count, err_count  saturating statistics
module mem_req_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  // The wait counter only has to reach TIMEOUT-1, and TIMEOUT <= 255.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    WAIT_RD = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic                    cmd_wr_reg;
  logic [ADDR_WIDTH-1:0]   mem_address_reg;
  logic [DATA_WIDTH-1:0]   mem_data_in_reg;
  logic [7:0]              timer_reg;
  logic                    rsp_wr_reg;
  logic                    rsp_err_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic                    rsp_handshake;
  logic                    timeout_hit;
  logic [2:0]              cnt_inc;

  assign rsp_handshake = (state_reg == RESP) && rsp_ready;
  assign timeout_hit   = (timer_reg == TIMEOUT_LAST);

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_wr ? WRITE : READ;
      WRITE:   state_next = RESP;
      READ:    state_next = WAIT_RD;
      WAIT_RD: if (mem_valid_out || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    mem_en    = 1'b0;
    rsp_valid = 1'b0;
    case (state_reg)
      IDLE:    req_ready = 1'b1;
      WRITE:   mem_en    = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // Command, memory-side and response registers
  // ---------------------------------------------------------------
  // The memory address/data registers double as the command latch, so
  // they are loaded on the accept edge and are already valid during
  // the WRITE/READ cycle that follows.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_wr_reg      <= 1'b0;
      mem_address_reg <= '0;
      mem_data_in_reg <= '0;
      timer_reg       <= '0;
      rsp_wr_reg      <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_rdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            cmd_wr_reg      <= req_wr;
            mem_address_reg <= req_addr;
            mem_data_in_reg <= req_wdata;
          end
        end
        WRITE: begin
          rsp_wr_reg    <= cmd_wr_reg;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= '0;
        end
        READ: begin
          timer_reg <= '0;
        end
        WAIT_RD: begin
          if (mem_valid_out) begin
            rsp_wr_reg    <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= mem_data_out;
          end else if (timeout_hit) begin
            rsp_wr_reg    <= 1'b0;
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= '0;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end
        RESP: begin
          // Response is held until accepted, then cleared so a stale
          // beat never lingers on the bus.
          if (rsp_ready) begin
            rsp_wr_reg    <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_address = mem_address_reg;
  assign mem_data_in = mem_data_in_reg;
  assign rsp_wr      = rsp_wr_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_rdata   = rsp_rdata_reg;

  // ---------------------------------------------------------------
  // Statistics: exactly one counter bumps per response handshake.
  //   index 0 = writes, 1 = good reads, 2 = timed-out reads
  // ---------------------------------------------------------------
  assign cnt_inc[0] = rsp_handshake &&  rsp_wr_reg;
  assign cnt_inc[1] = rsp_handshake && !rsp_wr_reg && !rsp_err_reg;
  assign cnt_inc[2] = rsp_handshake && !rsp_wr_reg &&  rsp_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] count_reg;
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != {CNT_WIDTH{1'b1}})) begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign wr_count  = g_cnt[0].count_reg;
  assign rd_count  = g_cnt[1].count_reg;
  assign err_count = g_cnt[2].count_reg;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl. A behavioural 16x32 memory sits on
// the memory side (reads registered, Valid_out the cycle after a read
// address is sampled). A second instance with 2-bit counters covers
// counter saturation.
module tb_mem_req_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int TO = 8;

  logic          CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  logic          RST_tb;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] mem_data_in;
  logic [AW-1:0] mem_address;
  logic          mem_en;
  logic [DW-1:0] mem_data_out;
  logic          mem_valid_out;
  logic [15:0]   wr_count, rd_count, err_count;

  // saturation instance
  logic          s_req_valid, s_req_ready, s_rsp_valid, s_rsp_wr, s_rsp_err;
  logic [DW-1:0] s_rsp_rdata, s_mem_data_in;
  logic [AW-1:0] s_mem_address;
  logic          s_mem_en;
  logic [1:0]    s_wr_count, s_rd_count, s_err_count;

  int vectors    = 0;
  int miscompares = 0;

  mem_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .CNT_WIDTH(16)) dut (
    .CLK(CLK_tb), .RST(RST_tb),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_data_in(mem_data_in), .mem_address(mem_address), .mem_en(mem_en),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  mem_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .CNT_WIDTH(2)) dut_sat (
    .CLK(CLK_tb), .RST(RST_tb),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_wr(1'b1),
    .req_addr(4'd7), .req_wdata(32'h12345678),
    .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_wr(s_rsp_wr),
    .rsp_err(s_rsp_err), .rsp_rdata(s_rsp_rdata),
    .mem_data_in(s_mem_data_in), .mem_address(s_mem_address), .mem_en(s_mem_en),
    .mem_data_out(32'h0), .mem_valid_out(1'b1),
    .wr_count(s_wr_count), .rd_count(s_rd_count), .err_count(s_err_count)
  );

  // Behavioural memory
  logic [DW-1:0] mem_model [16];
  logic          mem_clr;
  logic          force_invalid;
  always @(posedge CLK_tb) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= '0;
    end else if (mem_en) begin
      mem_model[mem_address] <= mem_data_in;
    end else begin
      mem_data_out <= mem_model[mem_address];
    end
    mem_valid_out <= !mem_en && !force_invalid;
  end

  task automatic tick();
    @(posedge CLK_tb);
    #1;
  endtask

  task automatic do_reset();
    RST_tb = 1'b0;
    req_valid = 1'b0; s_req_valid = 1'b0; rsp_ready = 1'b1; force_invalid = 1'b0;
    repeat (2) tick();
    RST_tb = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RST_tb = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    s_req_valid = 1'b0; rsp_ready = 1'b1; force_invalid = 1'b0;
    #2;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %0h exp 1", req_ready); end
    vectors++; if ({rsp_valid, rsp_wr, rsp_err, mem_en} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", {rsp_valid, rsp_wr, rsp_err, mem_en}); end
    vectors++; if (rsp_rdata !== '0 || mem_data_in !== '0 || mem_address !== '0) begin miscompares++; $display("FAIL reset_data rdata=%0h din=%0h addr=%0h exp 0", rsp_rdata, mem_data_in, mem_address); end
    vectors++; if (wr_count !== 0 || rd_count !== 0 || err_count !== 0) begin miscompares++; $display("FAIL reset_counts %0d/%0d/%0d exp 0/0/0", wr_count, rd_count, err_count); end
    repeat (2) tick();
    mem_clr = 1'b0;
    RST_tb = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_read();
    force_invalid = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd6;
    tick();                         // accept edge k -> READ
    req_valid = 1'b0;
    tick();                         // k+1 -> WAIT_RD
    vectors++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_address !== 4'd6) begin miscompares++; $display("FAIL midrd_busy ready=%0b valid=%0b addr=%0h exp 0/0/6", req_ready, rsp_valid, mem_address); end
    #2 RST_tb = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_en !== 1'b0) begin miscompares++; $display("FAIL midrd_async ready=%0b valid=%0b en=%0b exp 1/0/0", req_ready, rsp_valid, mem_en); end
    vectors++; if (mem_address !== '0 || rd_count !== 0 || err_count !== 0) begin miscompares++; $display("FAIL midrd_clear addr=%0h rd=%0d err=%0d exp 0", mem_address, rd_count, err_count); end
    force_invalid = 1'b0;
    tick();
    RST_tb = 1'b1;
    tick();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd0;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL midrd_read valid=%0b rdata=%0h err=%0b exp 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
    vectors++; if (rd_count !== 16'd1 || req_ready !== 1'b1) begin miscompares++; $display("FAIL midrd_count rd=%0d ready=%0b exp 1/1", rd_count, req_ready); end
    $display("test_reset_mid_read done");
  endtask

  task automatic test_write_read();
    do_reset();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd3; req_wdata = 32'hDEADBEEF;
    tick();                         // k
    req_valid = 1'b0;
    vectors++; if (mem_en !== 1'b1 || mem_address !== 4'd3 || mem_data_in !== 32'hDEADBEEF || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_drive en=%0b addr=%0h din=%0h valid=%0b exp 1/3/deadbeef/0", mem_en, mem_address, mem_data_in, rsp_valid); end
    tick();                         // k+1
    vectors++; if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== '0 || mem_en !== 1'b0) begin miscompares++; $display("FAIL wr_rsp valid=%0b wr=%0b err=%0b rdata=%0h en=%0b exp 1/1/0/0/0", rsp_valid, rsp_wr, rsp_err, rsp_rdata, mem_en); end
    tick();
    vectors++; if (wr_count !== 16'd1 || req_ready !== 1'b1) begin miscompares++; $display("FAIL wr_count got %0d ready=%0b exp 1/1", wr_count, req_ready); end
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd3; req_wdata = 32'h0;
    tick();                         // k
    req_valid = 1'b0;
    vectors++; if (mem_en !== 1'b0 || mem_address !== 4'd3 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_drive en=%0b addr=%0h valid=%0b exp 0/3/0", mem_en, mem_address, rsp_valid); end
    tick();                         // k+1
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_early valid=%0b exp 0", rsp_valid); end
    tick();                         // k+2
    vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || rsp_wr !== 1'b0) begin miscompares++; $display("FAIL rd_rsp valid=%0b rdata=%0h err=%0b wr=%0b exp 1/deadbeef/0/0", rsp_valid, rsp_rdata, rsp_err, rsp_wr); end
    tick();
    vectors++; if (rd_count !== 16'd1) begin miscompares++; $display("FAIL rd_count got %0d exp 1", rd_count); end
    $display("test_write_read done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      int n;
      int exp_n;
      logic [DW-1:0] exp_d;
      logic [AW-1:0] a;
      a = AW'(i % 16);
      exp_d = 32'(a) * 32'h01010101;
      req_valid = 1'b1; req_wr = (i < 16); req_addr = a;
      req_wdata = (i < 16) ? exp_d : 32'h0;
      exp_n = (i == 0) ? 2 : ((i < 16) ? 3 : 4);
      n = 0;
      do begin tick(); n++; end while (!rsp_valid && n < 10);
      vectors++; if (rsp_valid !== 1'b1 || n != exp_n) begin miscompares++; $display("FAIL b2b_timing op=%0d cycles=%0d valid=%0b exp %0d/1", i, n, rsp_valid, exp_n); end
      if (i >= 16) begin
        vectors++; if (rsp_rdata !== exp_d || rsp_err !== 1'b0) begin miscompares++; $display("FAIL b2b_read addr=%0d got %0h err=%0b exp %0h/0", a, rsp_rdata, rsp_err, exp_d); end
      end
      $display("b2b op=%0d wr=%0b addr=%0d rdata=%0h cycles=%0d", i, i < 16, a, rsp_rdata, n);
    end
    req_valid = 1'b0;
    tick();
    vectors++; if (wr_count !== 16'd16 || rd_count !== 16'd16 || err_count !== 16'd0) begin miscompares++; $display("FAIL b2b_counts %0d/%0d/%0d exp 16/16/0", wr_count, rd_count, err_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd3;
    tick();                         // accept read
    req_wr = 1'b1; req_addr = 4'd9; req_wdata = 32'hCAFEF00D;   // pending write
    repeat (2) tick();
    for (int c = 0; c < 5; c++) begin
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h03030303 || rsp_err !== 1'b0 || req_ready !== 1'b0 || mem_en !== 1'b0) begin miscompares++; $display("FAIL bp_hold cyc=%0d valid=%0b rdata=%0h err=%0b ready=%0b en=%0b exp 1/03030303/0/0/0", c, rsp_valid, rsp_rdata, rsp_err, req_ready, mem_en); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();                         // handshake
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rd_count !== 16'd1 || wr_count !== 16'd0) begin miscompares++; $display("FAIL bp_release ready=%0b valid=%0b rd=%0d wr=%0d exp 1/0/1/0", req_ready, rsp_valid, rd_count, wr_count); end
    tick();                         // pending write accepted
    req_valid = 1'b0;
    vectors++; if (mem_en !== 1'b1 || mem_address !== 4'd9 || mem_data_in !== 32'hCAFEF00D) begin miscompares++; $display("FAIL bp_pending en=%0b addr=%0h din=%0h exp 1/9/cafef00d", mem_en, mem_address, mem_data_in); end
    repeat (2) tick();
    vectors++; if (wr_count !== 16'd1) begin miscompares++; $display("FAIL bp_wrcount got %0d exp 1", wr_count); end
    $display("test_backpressure done");
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    force_invalid = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd5;
    tick();                         // k
    req_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!rsp_valid && n < 20);
    vectors++; if (rsp_valid !== 1'b1 || n != TO + 1) begin miscompares++; $display("FAIL to_latency cycles=%0d valid=%0b exp %0d/1", n, rsp_valid, TO + 1); end
    vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== '0 || rsp_wr !== 1'b0) begin miscompares++; $display("FAIL to_rsp err=%0b rdata=%0h wr=%0b exp 1/0/0", rsp_err, rsp_rdata, rsp_wr); end
    tick();
    vectors++; if (err_count !== 16'd1 || rd_count !== 16'd0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL to_count err=%0d rd=%0d ready=%0b exp 1/0/1", err_count, rd_count, req_ready); end
    force_invalid = 1'b0;
    $display("test_timeout done");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      logic [1:0] exp_c;
      exp_c = (i > 3) ? 2'd3 : 2'(i);
      s_req_valid = 1'b1;
      tick();
      s_req_valid = 1'b0;
      repeat (2) tick();
      vectors++; if (s_wr_count !== exp_c || s_rd_count !== 2'd0 || s_err_count !== 2'd0) begin miscompares++; $display("FAIL sat_count write=%0d got %0d/%0d/%0d exp %0d/0/0", i, s_wr_count, s_rd_count, s_err_count, exp_c); end
      $display("sat write=%0d wr_count=%0d", i, s_wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
